// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex sample type,
// bit-reverse helper and the reorder read-FSM state encoding.
package fft_pkg;

  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_LOG2N = 5;
  localparam int unsigned FFT_DW    = 18;

  typedef struct packed {
    logic [FFT_DW-1:0] re;
    logic [FFT_DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } rd_state_t;

  // Reverse the bit order of a bin index.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] a);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FFT_LOG2N; i++) begin
      r[i] = a[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two banks of N complex samples (ping-pong storage).
// Ports:
//   clk              - clock
//   we               - write enable
//   wr_bank/wr_addr  - write bank select and address
//   wr_data          - {re, im} to store
//   rd_bank/rd_addr  - asynchronous read bank select and address
//   rd_data          - {re, im} at the read location
module fft_pingpong_bank #(
  parameter int unsigned N     = 32,
  parameter int unsigned LOG2N = 5,
  parameter int unsigned DW    = 18
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [LOG2N-1:0]  wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic              rd_bank,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic [2*DW-1:0]   rd_data
);

  logic [2*DW-1:0] mem [2][N];

  // Contents need no reset: nothing is read before a full frame is written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order using a
// ping-pong buffer, streaming out over valid/ready.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   finish_i           - sample valid from FFT core (no backpressure)
//   X_r_i, X_i_i       - incoming sample, bit-reversed order
//   out_valid/out_ready- output handshake
//   Y_r, Y_i, bin_idx  - natural-order bin and its index (zero when idle)
//   ovf_o              - sticky: a frame was dropped
//   last_o             - final bin of a frame (only with FFT_REORDER_LAST_EN)
// Optional feature macro: FFT_REORDER_LAST_EN
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = FFT_N,
  parameter int unsigned LOG2N = FFT_LOG2N,
  parameter int unsigned DW    = FFT_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              finish_i,
  input  logic [DW-1:0]     X_r_i,
  input  logic [DW-1:0]     X_i_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     Y_r,
  output logic [DW-1:0]     Y_i,
  output logic [LOG2N-1:0]  bin_idx,
  output logic              ovf_o
`ifdef FFT_REORDER_LAST_EN
  ,
  output logic              last_o
`endif
);

  logic [1:0]       full;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic             dropping;
  logic             ovf;
  rd_state_t        state;
  rd_state_t        state_nxt;

  logic             frame_start;
  logic             drop_now;
  logic             wr_last;
  logic             we;
  logic             xfer;
  logic             rd_last;
  cplx_t            wr_data;
  cplx_t            rd_data;

  assign frame_start = finish_i & (wr_cnt == '0);
  // Drop decision is made on the first sample and held for the whole frame.
  assign drop_now    = frame_start ? full[wr_bank] : dropping;
  assign wr_last     = finish_i & (wr_cnt == LOG2N'(N-1));
  assign we          = finish_i & ~drop_now;
  assign xfer        = out_valid & out_ready;
  assign rd_last     = xfer & (rd_cnt == LOG2N'(N-1));

  assign full_set = (we & wr_last) ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = rd_last ? (2'b01 << rd_bank) : 2'b00;
  assign full_nxt = (full & ~full_clr) | full_set;

  assign wr_data = '{re: X_r_i, im: X_i_i};

  fft_pingpong_bank #(
    .N     (N),
    .LOG2N (LOG2N),
    .DW    (DW)
  ) u_bank (
    .clk     (clk),
    .we      (we),
    .wr_bank (wr_bank),
    .wr_addr (bitrev(wr_cnt)),
    .wr_data (wr_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  // Stay-in-DRAIN looks at full_nxt so a frame completing on the same edge
  // as the release of the current bank streams out with no bubble.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (rd_last && !full_nxt[~rd_bank]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      dropping <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      if (finish_i) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (frame_start) dropping <= full[wr_bank];
      end
      if (frame_start && full[wr_bank]) ovf <= 1'b1;
      if (we && wr_last) wr_bank <= ~wr_bank;
      if (xfer) rd_cnt <= rd_cnt + 1'b1;
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  assign Y_r     = out_valid ? rd_data.re : '0;
  assign Y_i     = out_valid ? rd_data.im : '0;
  assign bin_idx = out_valid ? rd_cnt : '0;
  assign ovf_o   = ovf;

`ifdef FFT_REORDER_LAST_EN
  assign last_o = out_valid & (rd_cnt == LOG2N'(N-1));
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
module tb_fft_out_reorder;

  localparam int N  = 32;
  localparam int LW = 5;
  localparam int DW = 18;
`ifdef FFT_REORDER_LAST_EN
  localparam int VW = 1 + LW + 2*DW + 2;
`else
  localparam int VW = 1 + LW + 2*DW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          finish_i = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] X_r_i = '0;
  logic [DW-1:0] X_i_i = '0;
  logic          out_valid;
  logic [DW-1:0] Y_r;
  logic [DW-1:0] Y_i;
  logic [LW-1:0] bin_idx;
  logic          ovf_o;
`ifdef FFT_REORDER_LAST_EN
  logic          last_o;
`endif

  always #5 clk = ~clk;

  fft_out_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .finish_i  (finish_i),
    .X_r_i     (X_r_i),
    .X_i_i     (X_i_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y_r       (Y_r),
    .Y_i       (Y_i),
    .bin_idx   (bin_idx),
    .ovf_o     (ovf_o)
`ifdef FFT_REORDER_LAST_EN
    ,
    .last_o    (last_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: accepted frames stored in natural bin order.
  logic [2*DW-1:0] q_data[$];
  int              q_done[$];   // edge number at which each frame completed
  logic [2*DW-1:0] cur[N];
  int              in_cnt;
  bit              in_drop;
  bit              m_ovf;
  bit              m_active;
  int              rd_idx;
  int              edge_no = 0;

  logic [VW-1:0]   obs_v;
  logic [VW-1:0]   exp_v;

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < LW; i++) if (k[i]) r |= (1 << (LW-1-i));
    return r;
  endfunction

  task automatic model_reset();
    q_data.delete();
    q_done.delete();
    in_cnt   = 0;
    in_drop  = 0;
    m_ovf    = 0;
    m_active = 0;
    rd_idx   = 0;
  endtask

  task automatic sample_obs();
`ifdef FFT_REORDER_LAST_EN
    obs_v = {out_valid, bin_idx, Y_r, Y_i, ovf_o, last_o};
`else
    obs_v = {out_valid, bin_idx, Y_r, Y_i, ovf_o};
`endif
  endtask

  // One clock: drive inputs, capture observed and expected outputs for the
  // cycle, then advance the model across the rising edge.
  task automatic tick(input bit fin, input logic [DW-1:0] re,
                      input logic [DW-1:0] im, input bit rdy);
    logic [2*DW-1:0] head;
    bit              last_e;
    bit              xfer;
    bit              popped;
    finish_i  = fin;
    X_r_i     = re;
    X_i_i     = im;
    out_ready = rdy;
    #1;
    head   = m_active ? q_data[rd_idx] : '0;
    last_e = m_active && (rd_idx == N-1);
    sample_obs();
`ifdef FFT_REORDER_LAST_EN
    exp_v = {m_active, (m_active ? LW'(rd_idx) : LW'(0)), head, m_ovf, last_e};
`else
    exp_v = {m_active, (m_active ? LW'(rd_idx) : LW'(0)), head, m_ovf};
    if (last_e) begin end
`endif
    xfer = m_active && rdy;
    @(posedge clk);
    edge_no++;
    popped = 0;
    if (fin) begin
      if (in_cnt == 0) begin
        in_drop = (q_done.size() == 2);
        if (in_drop) m_ovf = 1;
      end
      if (!in_drop) cur[brev(in_cnt)] = {re, im};
      in_cnt++;
      if (in_cnt == N) begin
        in_cnt = 0;
        if (!in_drop) begin
          for (int b = 0; b < N; b++) q_data.push_back(cur[b]);
          q_done.push_back(edge_no);
        end
      end
    end
    if (xfer) begin
      rd_idx++;
      if (rd_idx == N) begin
        rd_idx = 0;
        for (int b = 0; b < N; b++) void'(q_data.pop_front());
        void'(q_done.pop_front());
        popped = 1;
      end
    end
    if (popped) m_active = (q_done.size() > 0) && (q_done[0] <= edge_no);
    else if (!m_active) m_active = (q_done.size() > 0) && (q_done[0] < edge_no);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick(0, '0, '0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset: got %h want %h", obs_v, exp_v);
      end
    end
    rst_n = 1'b1;
    tick(0, '0, '0, 1);
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] kv;
    for (int c = 0; c < N + 40; c++) begin
      kv = DW'(c);
      if (c < N) tick(1, kv, -kv, 1);
      else       tick(0, '0, '0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL single c=%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] kv;
    for (int c = 0; c < N + 120; c++) begin
      kv = DW'(c);
      if (c < N) tick(1, kv, -kv, (c % 3) == 0);
      else       tick(0, '0, '0, (c % 3) == 0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL backpressure c=%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] kv;
    for (int c = 0; c < 2*N + 40; c++) begin
      if (c < N)        kv = DW'(1000 + c);
      else if (c < 2*N) kv = DW'(2000 + c - N);
      else              kv = '0;
      tick(c < 2*N, kv, -kv, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL back_to_back c=%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] kv;
    for (int c = 0; c < 3*N + 100; c++) begin
      kv = DW'(3000 + c);
      if (c < 3*N) tick(1, kv, ~kv, 0);
      else         tick(0, '0, '0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL overflow c=%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] kv;
    for (int c = 0; c < 18; c++) begin
      kv = DW'(500 + c);
      tick(1, kv, kv, 0);
    end
    rst_n = 1'b0;
    #1;
    sample_obs();
    checks++;
    if (obs_v !== '0) begin
      errors++;
      $display("FAIL reset_mid_zero: got %h want 0", obs_v);
    end
    model_reset();
    @(negedge clk);
    tick(0, '0, '0, 1);
    rst_n = 1'b1;
    for (int c = 0; c < N + 40; c++) begin
      kv = DW'(700 + c);
      if (c < N) tick(1, kv, -kv, 1);
      else       tick(0, '0, '0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_mid c=%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    bit            fin;
    bit            rdy;
    for (int c = 0; c < 1500; c++) begin
      r   = DW'($urandom);
      i   = DW'($urandom);
      fin = ($urandom_range(0, 3) != 0);
      rdy = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      tick(fin, r, i, rdy);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random c=%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
    for (int c = 0; c < 150; c++) begin
      tick(0, '0, '0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random_drain c=%0d: got %h want %h", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
